// File: rtl/rr_arbiter_16.sv
// -----------------------------------------------------------------------------
// rr_arbiter_16
//
// Sixteen-requester round-robin arbiter for one shared resource. A grant is
// held until the owner signals done, the owner drops its request, or the
// grant has been held TIMEOUT_CYCLES cycles. Priority rotates so the
// requester just above the last-served one is considered first.
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles a grant is held (1..65535), 0 = no timeout
//
// Ports
//   wb_clk_i        clock, rising edge
//   wb_rst_i        synchronous active-high reset
//   enable_i        allows new grants while high (never revokes a grant)
//   req_i[15:0]     level-sensitive requests
//   done_i          owner ends its tenure (only looked at while BUSY)
//   grant_o[15:0]   registered one-hot grant, zero when idle
//   grant_idx_o     registered index of the current/last grant
//   grant_valid_o   registered, a grant is active
//   timeout_o       registered one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module rr_arbiter_16 #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable_i,
   input  logic [15:0] req_i,
   input  logic        done_i,
   output logic [15:0] grant_o,
   output logic [3:0]  grant_idx_o,
   output logic        grant_valid_o,
   output logic        timeout_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 32'd0);
   // Release fires when the counter reaches TIMEOUT_CYCLES-1: the counter is
   // 0 in the first held cycle, so this yields exactly TIMEOUT_CYCLES cycles.
   localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 32'd0) ? 16'd0
                                     : 16'(TIMEOUT_CYCLES - 32'd1);

   // 4-to-16 one-hot decode
   function automatic logic [15:0] dec16(input logic [3:0] idx);
      logic [15:0] v;
      v = 16'h0001 << idx;
      return v;
   endfunction

   state_e      state_q,       state_d;
   logic [3:0]  last_idx_q,    last_idx_d;
   logic [15:0] cnt_q,         cnt_d;
   logic [15:0] grant_q,       grant_d;
   logic [3:0]  grant_idx_q,   grant_idx_d;
   logic        grant_valid_q, grant_valid_d;
   logic        timeout_q,     timeout_d;

   logic        win_found_s;
   logic [3:0]  win_idx_s;
   logic [3:0]  cand_s;
   logic        rel_done_s;
   logic        rel_abandon_s;
   logic        rel_timeout_s;
   logic        release_s;

   // Rotating-priority search: first set request above last_idx, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = 4'h0;
      cand_s      = 4'h0;
      for (int i = 1; i <= 16; i++) begin
         cand_s = last_idx_q + 4'(i);
         if (!win_found_s && req_i[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Release causes while BUSY; done and abandon outrank the timeout.
   always_comb begin
      rel_done_s    = done_i;
      rel_abandon_s = ~req_i[grant_idx_q];
      rel_timeout_s = TO_EN && (cnt_q == TO_LAST);
      release_s     = rel_done_s | rel_abandon_s | rel_timeout_s;
   end

   // Next-state and next-output logic for the IDLE/BUSY FSM.
   always_comb begin
      state_d       = state_q;
      last_idx_d    = last_idx_q;
      cnt_d         = cnt_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable_i && win_found_s) begin
               state_d       = BUSY;
               grant_idx_d   = win_idx_s;
               grant_d       = dec16(win_idx_s);
               grant_valid_d = 1'b1;
               cnt_d         = 16'd0;
            end else begin
               grant_d       = 16'h0000;
               grant_valid_d = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end else begin
               cnt_d = cnt_q;
            end
            if (release_s) begin
               state_d       = IDLE;
               grant_d       = 16'h0000;
               grant_valid_d = 1'b0;
               last_idx_d    = grant_idx_q;
               timeout_d     = rel_timeout_s & ~rel_done_s & ~rel_abandon_s;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d       = IDLE;
            grant_d       = 16'h0000;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q       <= IDLE;
         last_idx_q    <= 4'hF;
         cnt_q         <= 16'd0;
         grant_q       <= 16'h0000;
         grant_idx_q   <= 4'h0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_idx_q    <= last_idx_d;
         cnt_q         <= cnt_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_idx_o   = grant_idx_q;
   assign grant_valid_o = grant_valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_16
//
// Directed bench for rr_arbiter_16 built with TIMEOUT_CYCLES = 4. Inputs are
// changed and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_16;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] req;
   logic        done;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        timeout;

   int n_cmp;
   int n_err;

   rr_arbiter_16 #(.TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .enable_i      (enable),
      .req_i         (req),
      .done_i        (done),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid),
      .timeout_o     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output check against an expected grant index/valid/timeout.
   task automatic chk_all(input string tag, input logic v, input logic [3:0] idx,
                          input logic to);
      logic [15:0] g;
      g = v ? (16'h0001 << idx) : 16'h0000;
      chk({tag, ".valid"},   {15'd0, grant_valid}, {15'd0, v});
      chk({tag, ".idx"},     {12'd0, grant_idx},   {12'd0, idx});
      chk({tag, ".grant"},   grant,                g);
      chk({tag, ".timeout"}, {15'd0, timeout},     {15'd0, to});
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      enable = 1'b1;
      req    = 16'h0000;
      done   = 1'b0;

      // Reset state
      tick();
      tick();
      chk_all("reset", 1'b0, 4'd0, 1'b0);
      rst = 1'b0;
      tick();

      // Single requester, done ends tenure
      req = 16'h0001;
      tick();
      chk_all("single.grant", 1'b1, 4'd0, 1'b0);
      tick();
      chk_all("single.hold1", 1'b1, 4'd0, 1'b0);
      tick();
      chk_all("single.hold2", 1'b1, 4'd0, 1'b0);
      done = 1'b1;
      tick();
      chk_all("single.release", 1'b0, 4'd0, 1'b0);
      done = 1'b0;
      req  = 16'h0000;
      tick();

      // Fairness from a fresh reset: 0..15 then 0, idle cycle between
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      req  = 16'hFFFF;
      done = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk_all($sformatf("fair.grant%0d", k), 1'b1, 4'(k % 16), 1'b0);
         tick();
         chk_all($sformatf("fair.idle%0d", k), 1'b0, 4'(k % 16), 1'b0);
      end
      req  = 16'h0000;
      done = 1'b0;
      tick();

      // Timeout: requester 5 held 4 cycles, then pulse, then regrant
      req = 16'h0020;
      tick();
      chk_all("to.grant", 1'b1, 4'd5, 1'b0);
      tick();
      chk_all("to.hold2", 1'b1, 4'd5, 1'b0);
      tick();
      chk_all("to.hold3", 1'b1, 4'd5, 1'b0);
      tick();
      chk_all("to.hold4", 1'b1, 4'd5, 1'b0);
      tick();
      chk_all("to.revoke", 1'b0, 4'd5, 1'b1);
      tick();
      chk_all("to.regrant", 1'b1, 4'd5, 1'b0);
      req = 16'h0000;
      tick();
      chk_all("to.abandon", 1'b0, 4'd5, 1'b0);
      tick();

      // Wrap-around: last index 14, then 0, 1, 14
      req = 16'h4000;
      tick();
      chk_all("wrap.g14a", 1'b1, 4'd14, 1'b0);
      done = 1'b1;
      tick();
      chk_all("wrap.rel14a", 1'b0, 4'd14, 1'b0);
      req = 16'h4003;
      tick();
      chk_all("wrap.g0", 1'b1, 4'd0, 1'b0);
      tick();
      chk_all("wrap.rel0", 1'b0, 4'd0, 1'b0);
      tick();
      chk_all("wrap.g1", 1'b1, 4'd1, 1'b0);
      tick();
      chk_all("wrap.rel1", 1'b0, 4'd1, 1'b0);
      tick();
      chk_all("wrap.g14b", 1'b1, 4'd14, 1'b0);
      tick();
      chk_all("wrap.rel14b", 1'b0, 4'd14, 1'b0);
      req  = 16'h0000;
      done = 1'b0;
      tick();

      // done coinciding with the timeout cycle suppresses the pulse
      req = 16'h0020;
      tick();
      chk_all("sim.grant", 1'b1, 4'd5, 1'b0);
      tick();
      tick();
      tick();
      chk_all("sim.hold4", 1'b1, 4'd5, 1'b0);
      done = 1'b1;
      tick();
      chk_all("sim.release", 1'b0, 4'd5, 1'b0);
      done = 1'b0;
      tick();
      chk_all("sim.regrant", 1'b1, 4'd5, 1'b0);
      tick();
      chk_all("sim.hold", 1'b1, 4'd5, 1'b0);
      req = 16'h0000;
      tick();
      chk_all("sim.abandon", 1'b0, 4'd5, 1'b0);
      tick();

      // Reset in BUSY right where a timeout would fire, then enable gating
      req = 16'h0080;
      tick();
      chk_all("rst.grant7", 1'b1, 4'd7, 1'b0);
      tick();
      tick();
      tick();
      rst    = 1'b1;
      enable = 1'b0;
      tick();
      chk_all("rst.cleared", 1'b0, 4'd0, 1'b0);
      rst = 1'b0;
      req = 16'h0081;
      tick();
      chk_all("rst.disabled1", 1'b0, 4'd0, 1'b0);
      tick();
      chk_all("rst.disabled2", 1'b0, 4'd0, 1'b0);
      enable = 1'b1;
      tick();
      chk_all("rst.prio0", 1'b1, 4'd0, 1'b0);
      enable = 1'b0;
      tick();
      chk_all("rst.busy_no_revoke", 1'b1, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-requester round-robin arbiter that shares one resource between 16 requesters. The resource is selected by a 4-bit line index and a one-hot 16-bit select. The block tracks the last-served requester and holds a grant until the owner signals completion or a timeout fires. It also drives the 4-bit index and the matching one-hot vector to the shared resource. It sits between the requesters and the shared resource in the user project area, clocked from the Wishbone clock.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles a grant is held; range 1..65535; 0 disables the timeout.
- `wb_clk_i`  in  1  system clock; all logic is on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `enable_i`  in  1  arbitration enable; while low, no new grant is issued.
- `req_i`  in  16  request per requester; level-sensitive; requester holds it until granted or until it abandons.
- `done_i`  in  1  the current owner ends its tenure; sampled only in BUSY.
- `grant_o`  out  16  one-hot grant, registered; all-zero when no grant.
- `grant_idx_o`  out  4  index of the granted requester, registered; bit k of `grant_o` is set exactly when `grant_idx_o` = k and `grant_valid_o` = 1.
- `grant_valid_o`  out  1  a grant is active.
- `timeout_o`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: `grant_o`=16'h0000, `grant_idx_o`=4'h0, `grant_valid_o`=0, `timeout_o`=0. State=IDLE, `last_idx`=4'hF (so requester 0 has top priority after reset), timeout counter=0.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - If `enable_i`=1 and `req_i`≠0, pick the first set bit of `req_i` scanning upward from `last_idx`+1 (mod 16), wrapping.
  - Register the winner into `grant_idx_o` and `grant_o`, set `grant_valid_o`, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
- BUSY:
  - Grant outputs are held constant.
  - The counter increments each cycle, saturating at its width (16 bits).
  - Release occurs on the first of:
    - (a) `done_i`=1;
    - (b) `req_i[grant_idx_o]`=0, meaning the requester abandoned;
    - (c) `TIMEOUT_CYCLES`≠0 and counter = `TIMEOUT_CYCLES`-1.
  - On release: go to IDLE, clear `grant_o` and `grant_valid_o`, and load `last_idx` with `grant_idx_o`. `grant_idx_o` keeps its last value.
  - `timeout_o` pulses only if (c) is the cause and neither (a) nor (b) holds in the same cycle; (a) and (b) take precedence.
- `enable_i` low in BUSY does not revoke the current grant; it only blocks new grants in IDLE.
- Reset asserted in any state returns to reset values on the next edge, regardless of `done_i` or a pending timeout.
- Invariant: `grant_o` is always zero or one-hot, and equals the 4-to-16 decode of `grant_idx_o` gated by `grant_valid_o`.

## Timing
- Grant latency: a request sampled in IDLE at edge N appears on the outputs after edge N (1 cycle).
- Release: `done_i` sampled at edge M clears the grant after edge M. The next grant appears no earlier than after edge M+1, so there is one mandatory idle cycle between tenures.
- Timeout: a grant is held exactly `TIMEOUT_CYCLES` cycles. `timeout_o` is high in the cycle immediately after the last held cycle, aligned with `grant_valid_o` going low.
- Fairness: with all 16 requests continuously high, grants cycle 0,1,…,15,0. Each requester waits at most 15 tenures.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `req_i`=16'h0001 at cycle 2, `done_i` pulsed 3 cycles later.
  - `grant_o`=16'h0001 and `grant_idx_o`=0 one cycle after the request.
  - Grant drops after the `done_i` edge; `timeout_o` stays 0.
- `req_i`=16'hFFFF held, `done_i` pulsed each BUSY cycle.
  - Grant indices go 0,1,2,…,15,0, with one idle cycle between grants.
  - `grant_o` is always one-hot and matches `grant_idx_o`.
- `TIMEOUT_CYCLES`=4, `req_i`=16'h0020 held, `done_i`=0.
  - `grant_idx_o`=5 for exactly 4 cycles.
  - Then `grant_valid_o`=0 with a single-cycle `timeout_o`=1.
  - Requester 5 is regranted after one idle cycle.
- Wrap-around: last grant index 14, then `req_i`=16'h4003.
  - The next grants are 0 then 1 then 14, not 14 first.
- Simultaneous events: `TIMEOUT_CYCLES`=4 with `done_i`=1 in the 4th held cycle.
  - The grant is released and `timeout_o` stays 0.
  - Separately, drop `req_i[idx]` mid-tenure: the grant is released the next cycle.
- Assert `wb_rst_i` mid-BUSY with `enable_i`=0 afterwards.
  - All outputs are 0 after the edge.
  - No grant is issued while `enable_i`=0.
  - After raising `enable_i`, requester 0 wins over a set including 0 and 7.
